// File: rtl/aes_key_schedule_if.sv
// Bus bundle for the AES-128 key schedule: start/key load, status flags and
// the round-key read port. The master drives requests; the slave (the key
// schedule) returns status and read data.
interface aes_key_schedule_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [127:0]     key_in;
    logic             busy;
    logic             ready;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_rev;
    logic [127:0]     round_key;
    logic             rk_valid;
    logic             rd_err;

    modport master (
        output start, key_in, rd_en, rd_idx, rd_rev,
        input  busy, ready, round_key, rk_valid, rd_err
    );

    modport slave (
        input  start, key_in, rd_en, rd_idx, rd_rev,
        output busy, ready, round_key, rk_valid, rd_err
    );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion. The cipher key is stored as rk[0], then
// one round key is derived per clock from the previous one. Once all NR+1
// keys are stored, any of them can be read by index in forward or reversed
// order, with one registered result per cycle.
module aes_key_schedule #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_schedule_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        // Entry x lives at bit offset (255 - x) * 8, and 255 - x == ~x.
        base = {~x, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
        logic [7:0] rc;
        case (r)
            IDX_W'(1):  rc = 8'h01;
            IDX_W'(2):  rc = 8'h02;
            IDX_W'(3):  rc = 8'h04;
            IDX_W'(4):  rc = 8'h08;
            IDX_W'(5):  rc = 8'h10;
            IDX_W'(6):  rc = 8'h20;
            IDX_W'(7):  rc = 8'h40;
            IDX_W'(8):  rc = 8'h80;
            IDX_W'(9):  rc = 8'h1b;
            IDX_W'(10): rc = 8'h36;
            default:    rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [127:0]     rk_q [0:NR];
    logic [127:0]     round_key_q, round_key_d;
    logic             rk_valid_q, rk_valid_d;
    logic             rd_err_q, rd_err_d;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [127:0]     wr_data;

    logic [127:0]     prev_key;
    logic [31:0]      rot_word;
    logic [31:0]      sub_word;
    logic [31:0]      w0_n, w1_n, w2_n, w3_n;
    logic [127:0]     next_key;
    logic [IDX_W-1:0] rd_sel;

    // The round being produced is cnt_q, derived from the key stored just before it.
    assign prev_key = rk_q[cnt_q - 1'b1];
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    // One S-box lookup per byte of the rotated last word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
        assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
    end

    // Next round key: chained XOR across the four words.
    always_comb begin
        w0_n     = prev_key[127:96] ^ sub_word ^ {rcon(cnt_q), 24'h0};
        w1_n     = prev_key[95:64] ^ w0_n;
        w2_n     = prev_key[63:32] ^ w1_n;
        w3_n     = prev_key[31:0]  ^ w2_n;
        next_key = {w0_n, w1_n, w2_n, w3_n};
    end

    // Reversed reads mirror the index around NR.
    assign rd_sel = bus.rd_rev ? (LAST_IDX - bus.rd_idx) : bus.rd_idx;

    // Next-state, key-store write and read-port decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        wr_idx      = cnt_q;
        wr_data     = next_key;
        round_key_d = round_key_q;
        rk_valid_d  = 1'b0;
        rd_err_d    = 1'b0;

        case (state_q)
            S_IDLE, S_READY: begin
                if (bus.start) begin
                    state_d = S_EXPAND;
                    cnt_d   = IDX_W'(1);
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    wr_data = bus.key_in;
                end
            end
            S_EXPAND: begin
                // start is deliberately ignored here so an expansion always completes.
                wr_en = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A concurrent start takes priority over a read, so the read is rejected.
        if (bus.rd_en) begin
            if (state_q == S_READY && bus.rd_idx <= LAST_IDX && !bus.start) begin
                round_key_d = rk_q[rd_sel];
                rk_valid_d  = 1'b1;
            end else begin
                rd_err_d = 1'b1;
            end
        end
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            round_key_q <= '0;
            rk_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            round_key_q <= round_key_d;
            rk_valid_q  <= rk_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Round-key store, one entry written per cycle during expansion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else if (wr_en) begin
            rk_q[wr_idx] <= wr_data;
        end
    end

    assign bus.busy      = (state_q == S_EXPAND);
    assign bus.ready     = (state_q == S_READY);
    assign bus.round_key = round_key_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed + randomized bench for aes_key_schedule. The reference model
// derives the S-box from GF(2^8) inversion and the affine map, and the
// round constants by repeated doubling, then expands keys word by word.
module tb_aes_key_schedule;
    localparam int NR = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] exp_rk [0:NR];
    logic [127:0] last_key;

    aes_key_schedule_if #(.IDX_W(4)) bus ();

    aes_key_schedule #(.NR(NR), .IDX_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {model_sbox(t[31:24]), model_sbox(t[23:16]),
                     model_sbox(t[15:8]), model_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read in the current cycle and check the registered result.
    task automatic do_read(input string tag, input int idx, input logic rev, input logic good,
                           input logic [127:0] exp_key);
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'(idx);
        bus.rd_rev = rev;
        step();
        chk({tag, ".valid"}, 128'(bus.rk_valid), 128'(good));
        chk({tag, ".err"}, 128'(bus.rd_err), 128'(!good));
        chk({tag, ".key"}, bus.round_key, good ? exp_key : last_key);
        if (good) last_key = exp_key;
        $display("read %s idx=%0d rev=%0d valid=%0d err=%0d key=%h", tag, idx, rev,
                 bus.rk_valid, bus.rd_err, bus.round_key);
    endtask

    task automatic idle_read();
        bus.rd_en = 1'b0;
    endtask

    // Start a key, then count edges (the start edge is the first) until ready.
    task automatic start_key(input string tag, input logic [127:0] key, input logic with_read);
        int n;
        model_expand(key);
        bus.start  = 1'b1;
        bus.key_in = key;
        bus.rd_en  = with_read;
        bus.rd_idx = 4'd1;
        bus.rd_rev = 1'b0;
        step();
        bus.start = 1'b0;
        bus.rd_en = 1'b0;
        if (with_read) begin
            chk({tag, ".start_rd_err"}, 128'(bus.rd_err), 128'(1));
            chk({tag, ".start_rd_valid"}, 128'(bus.rk_valid), 128'(0));
        end
        chk({tag, ".busy"}, 128'(bus.busy), 128'(1));
        chk({tag, ".ready_low"}, 128'(bus.ready), 128'(0));
        n = 1;
        while (!bus.ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, 128'(n), 128'(11));
        chk({tag, ".busy_done"}, 128'(bus.busy), 128'(0));
        $display("start %s key=%h edges_to_ready=%0d", tag, key, n);
    endtask

    task automatic random_reads(input string tag, input int count);
        int idx;
        logic rev;
        for (int i = 0; i < count; i++) begin
            idx = int'($urandom_range(0, NR));
            rev = 1'($urandom_range(0, 1));
            do_read(tag, idx, rev, 1'b1, rev ? exp_rk[NR - idx] : exp_rk[idx]);
        end
        idle_read();
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] fips_key;
        logic [127:0] rkey;
        int n;

        fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        last_key   = '0;
        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rd_en  = 1'b0;
        bus.rd_idx = '0;
        bus.rd_rev = 1'b0;

        // Reset state
        step(); step();
        chk("rst.busy", 128'(bus.busy), 128'(0));
        chk("rst.ready", 128'(bus.ready), 128'(0));
        chk("rst.rk_valid", 128'(bus.rk_valid), 128'(0));
        chk("rst.rd_err", 128'(bus.rd_err), 128'(0));
        chk("rst.round_key", bus.round_key, 128'h0);
        rst_n = 1'b1;
        step();

        // Read before any key is loaded
        do_read("idle_rd", 0, 1'b0, 1'b0, '0);
        idle_read();
        step();

        // FIPS-197 expansion with a read and a stray start during EXPAND
        model_expand(fips_key);
        bus.start  = 1'b1;
        bus.key_in = fips_key;
        step();
        bus.start = 1'b0;
        chk("fips.busy", 128'(bus.busy), 128'(1));
        n = 1;
        while (!bus.ready && n < 20) begin
            if (n == 3) begin bus.rd_en = 1'b1; bus.rd_idx = 4'd1; bus.rd_rev = 1'b0; end
            if (n == 5) begin bus.start = 1'b1; bus.key_in = {$urandom, $urandom, $urandom, $urandom}; end
            step();
            n++;
            if (n == 4) begin
                chk("expand_rd.err", 128'(bus.rd_err), 128'(1));
                chk("expand_rd.valid", 128'(bus.rk_valid), 128'(0));
                bus.rd_en = 1'b0;
            end
            if (n == 6) bus.start = 1'b0;
        end
        chk("fips.latency", 128'(n), 128'(11));
        $display("start fips key=%h edges_to_ready=%0d", fips_key, n);

        do_read("fips_idx1", 1, 1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
        idle_read();
        step();
        chk("fips_idx1.pulse", 128'(bus.rk_valid), 128'(0));
        chk("fips_idx1.hold", bus.round_key, last_key);
        do_read("fips_idx10", 10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_read("fips_rev0", 0, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_read("fips_rev10", 10, 1'b1, 1'b1, fips_key);

        // Sweep forward back-to-back, then out-of-range indices
        for (int i = 0; i <= NR; i++) do_read("sweep", i, 1'b0, 1'b1, exp_rk[i]);
        do_read("oob11", 11, 1'b0, 1'b0, '0);
        do_read("oob15", 15, 1'b1, 1'b0, '0);
        idle_read();
        step();
        random_reads("fips_rand", 12);

        // Re-key with all zeros, start and read in the same cycle
        start_key("zero", 128'h0, 1'b1);
        do_read("zero_idx1", 1, 1'b0, 1'b1, 128'h62636363626363636263636362636363);
        idle_read();
        step();
        random_reads("zero_rand", 8);

        // Random keys
        for (int k = 0; k < 3; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            start_key("rand", rkey, 1'b0);
            random_reads("rand_rd", 8);
        end

        // Asynchronous reset in the middle of an expansion
        rkey = {$urandom, $urandom, $urandom, $urandom};
        bus.start  = 1'b1;
        bus.key_in = rkey;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 128'(bus.busy), 128'(0));
        chk("arst.ready", 128'(bus.ready), 128'(0));
        chk("arst.round_key", bus.round_key, 128'h0);
        last_key = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        do_read("post_rst_rd", 0, 1'b0, 1'b0, '0);
        idle_read();
        step();
        rkey = {$urandom, $urandom, $urandom, $urandom};
        start_key("post_rst", rkey, 1'b0);
        random_reads("post_rst_rd", 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
